// File: rtl/inst_encoder_loader.sv
// Field-level MIPS instruction encoder that streams words into instruction memory.
// Optional readback verification is enabled with INST_ENC_READBACK_EN.
module inst_encoder_loader #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int                MAX_INSTS = 256,
    parameter int                CNT_W     = 9
) (
    input  logic              inclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
`ifdef INST_ENC_READBACK_EN
    output logic              im_re,
    input  logic [31:0]       im_rdata,
    output logic              err_verify,
`endif
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  inst_count,
    output logic              err_illegal,
    output logic              err_full
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef INST_ENC_READBACK_EN
    localparam logic [2:0] S_VER1  = 3'd4;
    localparam logic [2:0] S_VER2  = 3'd5;
`endif

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       word_q, word_d;
    logic              ill_q, ill_d;
    logic              full_err_q, full_err_d;
    logic [31:0]       word_enc;
    logic              legal;
    logic              full;
    logic              mem_access;
`ifdef INST_ENC_READBACK_EN
    logic              ver_q, ver_d;
`endif

    always_comb begin
        word_enc = '0;
        legal    = 1'b1;
        case (op_sel)
            5'd0:  word_enc = {6'h00, rs, rt, rd, 5'd0, 6'h20};
            5'd1:  word_enc = {6'h00, rs, rt, rd, 5'd0, 6'h21};
            5'd2:  word_enc = {6'h00, rs, rt, rd, 5'd0, 6'h22};
            5'd3:  word_enc = {6'h00, rs, rt, rd, 5'd0, 6'h23};
            5'd4:  word_enc = {6'h00, rs, rt, rd, 5'd0, 6'h24};
            5'd5:  word_enc = {6'h00, rs, rt, rd, 5'd0, 6'h25};
            5'd6:  word_enc = {6'h00, rs, rt, rd, 5'd0, 6'h26};
            5'd7:  word_enc = {6'h00, 5'd0, rt, rd, shamt, 6'h00};
            5'd8:  word_enc = {6'h00, 5'd0, rt, rd, shamt, 6'h02};
            5'd9:  word_enc = {6'h00, 5'd0, rt, rd, shamt, 6'h03};
            5'd10: word_enc = {6'h08, rs, rt, imm};
            5'd11: word_enc = {6'h09, rs, rt, imm};
            5'd12: word_enc = {6'h0C, rs, rt, imm};
            5'd13: word_enc = {6'h0D, rs, rt, imm};
            5'd14: word_enc = {6'h23, rs, rt, imm};
            5'd15: word_enc = {6'h2B, rs, rt, imm};
            5'd16: word_enc = {6'h04, rs, rt, imm};
            5'd17: word_enc = {6'h05, rs, rt, imm};
            5'd18: word_enc = {6'h02, target};
            default: legal = 1'b0;
        endcase
    end

    assign full = (cnt_q == CNT_W'(MAX_INSTS));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        ill_d      = ill_q;
        full_err_d = full_err_q;
`ifdef INST_ENC_READBACK_EN
        ver_d      = ver_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    addr_d     = BASE_ADDR;
                    cnt_d      = '0;
                    ill_d      = 1'b0;
                    full_err_d = 1'b0;
`ifdef INST_ENC_READBACK_EN
                    ver_d      = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (in_valid && !full) begin
                    if (legal) begin
                        word_d  = word_enc;
                        state_d = S_WRITE;
                    end else begin
                        ill_d = 1'b1;
                    end
                end else begin
                    if (in_valid) full_err_d = 1'b1;
                    if (finish) state_d = S_DONE;
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef INST_ENC_READBACK_EN
                // address advance deferred so the readback reuses the write address
                state_d = S_VER1;
`else
                addr_d  = addr_q + ADDR_W'(4);
                state_d = S_LOAD;
`endif
            end
`ifdef INST_ENC_READBACK_EN
            S_VER1: state_d = S_VER2;
            S_VER2: begin
                if (im_rdata != word_q) ver_d = 1'b1;
                addr_d  = addr_q + ADDR_W'(4);
                state_d = S_LOAD;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= BASE_ADDR;
            cnt_q      <= '0;
            word_q     <= '0;
            ill_q      <= 1'b0;
            full_err_q <= 1'b0;
`ifdef INST_ENC_READBACK_EN
            ver_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            ill_q      <= ill_d;
            full_err_q <= full_err_d;
`ifdef INST_ENC_READBACK_EN
            ver_q      <= ver_d;
`endif
        end
    end

    assign im_we       = (state_q == S_WRITE);
`ifdef INST_ENC_READBACK_EN
    assign im_re       = (state_q == S_VER1);
    assign err_verify  = ver_q;
    assign mem_access  = im_we | im_re;
`else
    assign mem_access  = im_we;
`endif
    assign im_addr     = mem_access ? addr_q : '0;
    assign im_wdata    = im_we ? word_q : '0;
    assign in_ready    = (state_q == S_LOAD) && !full;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign inst_count  = cnt_q;
    assign err_illegal = ill_q;
    assign err_full    = full_err_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Randomized self-checking bench for inst_encoder_loader against a table-driven encoding model.
module tb_inst_encoder_loader;

    localparam int MAXI = 8;

    logic        inclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        finish = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  op_sel = '0, rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        in_ready, im_we, busy, done, err_illegal, err_full;
    logic [31:0] im_addr, im_wdata;
    logic [8:0]  inst_count;
`ifdef INST_ENC_READBACK_EN
    logic        im_re, err_verify;
    logic [31:0] im_rdata;
    logic [31:0] mem [0:255];
    always @(posedge inclk) begin
        if (im_we) mem[im_addr[9:2]] <= im_wdata;
        if (im_re) im_rdata <= mem[im_addr[9:2]] ^ {31'd0, (im_addr == 32'h4)};
    end
`endif

    inst_encoder_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .MAX_INSTS(MAXI), .CNT_W(9)) dut (
        .inclk(inclk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
`ifdef INST_ENC_READBACK_EN
        .im_re(im_re), .im_rdata(im_rdata), .err_verify(err_verify),
`endif
        .busy(busy), .done(done), .inst_count(inst_count),
        .err_illegal(err_illegal), .err_full(err_full)
    );

    always #5 inclk = ~inclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model state
    logic [63:0] exp_q[$];
    logic [63:0] cap_q[$];
    int unsigned m_addr, m_cnt;
    bit          m_ill, m_full, m_ver;

    int unsigned funct_t [10] = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26, 32'h00, 32'h02, 32'h03};
    int unsigned opc_t   [8]  = '{32'h08, 32'h09, 32'h0C, 32'h0D, 32'h23, 32'h2B, 32'h04, 32'h05};

    function automatic logic [31:0] ref_word(input int unsigned op, input int unsigned f_rs,
            input int unsigned f_rt, input int unsigned f_rd, input int unsigned f_sh,
            input int unsigned f_imm, input int unsigned f_tgt);
        int unsigned w;
        if (op <= 9) begin
            if (op >= 7) w = f_rt * (1 << 16) + f_rd * (1 << 11) + f_sh * (1 << 6) + funct_t[op];
            else w = f_rs * (1 << 21) + f_rt * (1 << 16) + f_rd * (1 << 11) + funct_t[op];
        end else if (op <= 17) begin
            w = opc_t[op - 10] * (1 << 26) + f_rs * (1 << 21) + f_rt * (1 << 16) + f_imm;
        end else begin
            w = 2 * (1 << 26) + f_tgt;
        end
        return w;
    endfunction

    always @(negedge inclk) if (rst_n && im_we) cap_q.push_back({im_addr, im_wdata});

    task automatic model_clear();
        exp_q.delete();
        cap_q.delete();
        m_addr = 0; m_cnt = 0; m_ill = 0; m_full = 0; m_ver = 0;
    endtask

    task automatic do_start();
        @(posedge inclk); #1 start = 1'b1;
        @(posedge inclk); #1 start = 1'b0;
        model_clear();
    endtask

    task automatic send(input int unsigned op, input int unsigned a, input int unsigned b,
                        input int unsigned c, input int unsigned s, input int unsigned i,
                        input int unsigned t, input bit with_fin);
        int n;
        @(posedge inclk); #1;
        op_sel = 5'(op); rs = 5'(a); rt = 5'(b); rd = 5'(c); shamt = 5'(s);
        imm = 16'(i); target = 26'(t);
        in_valid = 1'b1;
        if (m_cnt == MAXI) begin
            repeat (3) begin
                @(negedge inclk);
                chk("ready_when_full", in_ready, 1'b0);
            end
            @(posedge inclk); #1 in_valid = 1'b0;
            m_full = 1;
            return;
        end
        finish = with_fin;
        n = 0;
        @(negedge inclk);
        while (!in_ready && n < 20) begin n++; @(negedge inclk); end
        chk("ready_wait", in_ready, 1'b1);
        @(posedge inclk); #1 in_valid = 1'b0; finish = 1'b0;
        if (op <= 18) begin
            exp_q.push_back({m_addr[31:0], ref_word(op, a, b, c, s, i, t)});
            if (m_addr == 4) m_ver = 1;
            m_addr += 4;
            m_cnt++;
        end else begin
            m_ill = 1;
        end
    endtask

    task automatic send_rand(input int unsigned op);
        send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), $urandom & 32'h3FF_FFFF, 1'b0);
    endtask

    task automatic end_session();
        int n = 0;
        @(negedge inclk);
        while (im_we && n < 20) begin n++; @(negedge inclk); end
`ifdef INST_ENC_READBACK_EN
        repeat (3) @(negedge inclk);
`endif
        finish = 1'b1;
        @(posedge inclk); #1 finish = 1'b0;
        @(negedge inclk);
        chk("done_pulse", done, 1'b1);
        @(negedge inclk);
        chk("done_low", done, 1'b0);
        chk("busy_after", busy, 1'b0);
        chk("inst_count", inst_count, m_cnt);
        chk("err_illegal", err_illegal, m_ill);
        chk("err_full", err_full, m_full);
`ifdef INST_ENC_READBACK_EN
        chk("err_verify", err_verify, m_ver);
`endif
        chk("num_writes", cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) chk("write", cap_q[i], exp_q[i]);
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge inclk);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_we", im_we, 1'b0);
        chk("rst_addr", im_addr, 32'h0);
        chk("rst_wdata", im_wdata, 32'h0);
        chk("rst_count", inst_count, 0);
        chk("rst_errs", {err_illegal, err_full}, 2'b00);
        rst_n = 1'b1;

        // finish while idle is ignored
        @(posedge inclk); #1 finish = 1'b1;
        @(posedge inclk); #1 finish = 1'b0;
        @(negedge inclk);
        chk("idle_finish_busy", busy, 1'b0);
        chk("idle_finish_done", done, 1'b0);

        do_start();
        send(0, 1, 2, 3, 0, 0, 0, 1'b0);
        end_session();
        chk("add_word", cap_q[0], {32'h0, 32'h00221820});

        do_start();
        send(10, 0, 9, 17, 3, 5, 0, 1'b0);
        send(14, 29, 8, 5, 9, 4, 0, 1'b0);
        send(16, 1, 2, 30, 1, 16'hFFFF, 0, 1'b0);
        send(7, 7, 3, 2, 4, 0, 0, 1'b0);
        send(18, 3, 4, 5, 6, 7, 32'h10, 1'b0);
        end_session();
        chk("mix0", cap_q[0], {32'h0,  32'h20090005});
        chk("mix1", cap_q[1], {32'h4,  32'h8FA80004});
        chk("mix2", cap_q[2], {32'h8,  32'h1022FFFF});
        chk("mix3", cap_q[3], {32'hC,  32'h00031100});
        chk("mix4", cap_q[4], {32'h10, 32'h08000010});

        do_start();
        send(25, 1, 2, 3, 4, 5, 6, 1'b0);
        @(negedge inclk);
        chk("ill_flag", err_illegal, 1'b1);
        chk("ill_count", inst_count, 0);
        chk("ill_nowrite", cap_q.size(), 0);
        send(0, 4, 5, 6, 0, 0, 0, 1'b1);  // finish alongside a transfer is ignored
        @(negedge inclk);
        chk("fin_with_xfer_busy", busy, 1'b1);
        end_session();

        do_start();
        for (int i = 0; i < MAXI; i++) send_rand($urandom_range(0, 18));
        send_rand(0);
        end_session();

        // asynchronous reset in the middle of a write
        do_start();
        @(posedge inclk); #1 op_sel = 5'd1; in_valid = 1'b1;
        @(posedge inclk); #2 in_valid = 1'b0;
        chk("we_before_rst", im_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("we_async_rst", im_we, 1'b0);
        chk("busy_async_rst", busy, 1'b0);
        chk("count_async_rst", inst_count, 0);
        @(negedge inclk); rst_n = 1'b1;
        model_clear();
        do_start();
        send_rand(0);
        end_session();

        for (int s = 0; s < 8; s++) begin
            int unsigned nreq = $urandom_range(0, MAXI + 2);
            do_start();
            for (int k = 0; k < nreq; k++) begin
                if ($urandom_range(0, 9) < 8) send_rand($urandom_range(0, 18));
                else send_rand($urandom_range(19, 31));
                if (k == 1) begin
                    // start while in a session is ignored
                    @(posedge inclk); #1 start = 1'b1;
                    @(posedge inclk); #1 start = 1'b0;
                end
            end
            end_session();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Assembles field-level instruction requests (mnemonic select plus register, immediate and target fields) into 32-bit MIPS words for the supported instruction subset.
- Writes the words sequentially into instruction memory through a write port.
- Testbench and boot-time program loader for the single-cycle CPU. It produces exactly the encodings the CPU's instruction decoder consumes.

Parameters:
- ADDR_W, 32, width of im_addr in bits.
- BASE_ADDR, 32'h0000_0000, byte address of the first written instruction; must be word aligned.
- MAX_INSTS, 256, maximum number of instructions written per load session.
- CNT_W, 9, width of inst_count; must hold MAX_INSTS.

Ports:
- inclk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that opens a load session; honoured only in IDLE.
- finish  input  1  one-cycle pulse that closes the session; honoured only in LOAD.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid and in_ready are both high.
- op_sel  input  5  0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 sll, 8 srl, 9 sra, 10 addi, 11 addiu, 12 andi, 13 ori, 14 lw, 15 sw, 16 beq, 17 bne, 18 j; values 19-31 are illegal.
- rs, rt, rd, shamt  input  5 each  instruction fields.
- imm  input  16  I-type immediate.
- target  input  26  J-type target.
- im_we  output  1  instruction memory write strobe.
- im_addr  output  ADDR_W  byte address of the write.
- im_wdata  output  32  encoded instruction word.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a session ends.
- inst_count  output  CNT_W  number of words written in the current session.
- err_illegal  output  1  sticky: an illegal op_sel was accepted.
- err_full  output  1  sticky: in_valid was asserted while the session was full.

Behaviour:
- Reset values: all outputs 0, state IDLE, address register = BASE_ADDR. Reset takes effect asynchronously, so im_we drops immediately even in the middle of a write; no partial session state survives.
- State IDLE:
  - in_ready = 0.
  - start -> LOAD; same edge: addr = BASE_ADDR, inst_count = 0, err_illegal = 0, err_full = 0.
- State LOAD:
  - in_ready = (inst_count != MAX_INSTS).
  - Transfer with a legal op_sel: the encoded word is registered, then -> WRITE.
  - Transfer with an illegal op_sel: err_illegal is set, nothing is written, stay in LOAD.
  - If a transfer and finish occur in the same cycle, the transfer wins and finish is ignored.
  - finish with no transfer -> DONE.
- State WRITE (exactly 1 cycle):
  - im_we = 1, im_addr = address register, im_wdata = registered word.
  - Next edge: addr += 4 (mod 2^ADDR_W), inst_count += 1, -> LOAD (or VERIFY when the optional feature is enabled).
  - Throughput: 1 instruction per 2 cycles.
- State DONE: done = 1 for one cycle, -> IDLE. inst_count and the error flags hold until the next start.
- Full condition: when inst_count == MAX_INSTS, in_ready = 0, and any in_valid seen in LOAD sets err_full. finish still closes the session.
- start outside IDLE and finish outside LOAD are ignored.
- Encoding rules:
  - R-type: {6'b0, rs, rt, rd, shamt, funct}. funct: add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, sll 00, srl 02, sra 03 (hex). For sll/srl/sra the rs field is forced to 0. For the non-shift R-types the shamt field is forced to 0.
  - I-type: {op, rs, rt, imm}. op: addi 08, addiu 09, andi 0C, ori 0D, lw 23, sw 2B, beq 04, bne 05 (hex).
  - J-type: j = {6'h02, target}.
- Unused field inputs are don't-care and must not affect the encoded word.

Optional Feature:
- INST_ENC_READBACK_EN defined: adds ports im_re (output 1), im_rdata (input 32) and err_verify (output 1, sticky, cleared on start).
  - After WRITE the block enters VERIFY for 2 cycles:
    - Cycle 1: im_re = 1 with the same im_addr as the write.
    - Cycle 2: im_rdata is compared against the written word; on mismatch err_verify is set.
  - Then -> LOAD. Throughput: 1 instruction per 4 cycles.
- INST_ENC_READBACK_EN undefined: these ports and the VERIFY state do not exist; WRITE returns directly to LOAD.

Test Plan:
- add: start; op_sel=0, rs=1, rt=2, rd=3 -> one im_we pulse, im_addr=0x0, im_wdata=0x00221820; inst_count=1.
- Mixed sequence: addi rt=9 rs=0 imm=5; lw rt=8 rs=29 imm=4; beq rs=1 rt=2 imm=FFFF; sll rd=2 rt=3 shamt=4 with rs=7; j target=0x10 -> words 0x20090005, 0x8FA80004, 0x1022FFFF, 0x00031100, 0x08000010 at addresses 0x0, 0x4, 0x8, 0xC, 0x10. The sll word confirms rs is forced to 0.
- Illegal op_sel: op_sel=25 accepted -> err_illegal=1, no im_we, inst_count unchanged. A following legal add is written at the next address.
- Full session: MAX_INSTS=4; 4 writes, then in_valid held -> in_ready=0, err_full=1; finish -> done pulse, busy=0, inst_count=4.
- Reset mid-write: rst_n low during WRITE -> im_we=0 asynchronously; after release, state IDLE, inst_count=0, and start restarts writing at BASE_ADDR.
- With INST_ENC_READBACK_EN: memory model corrupts bit 0 of the word at 0x4 -> err_verify=1 after the second write; other words pass.
